// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Serialises single-beat read/write commands and routes read data back by requester id.
module mem_rr_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int WDATA_W = 4,
    parameter int RDATA_W = 8,
    parameter int RD_LAT  = 1
) (
    input  logic               i_sys_clk,
    input  logic               i_rst,
    input  logic               i_req0,
    input  logic               i_we0,
    input  logic [ADDR_W-1:0]  i_addr0,
    input  logic [WDATA_W-1:0] i_wdata0,
    output logic               o_gnt0,
    output logic               o_rvalid0,
    output logic [RDATA_W-1:0] o_rdata0,
    input  logic               i_req1,
    input  logic               i_we1,
    input  logic [ADDR_W-1:0]  i_addr1,
    input  logic [WDATA_W-1:0] i_wdata1,
    output logic               o_gnt1,
    output logic               o_rvalid1,
    output logic [RDATA_W-1:0] o_rdata1,
    output logic               o_mem_wr,
    output logic               o_mem_rd,
    output logic [ADDR_W-1:0]  o_mem_wr_addr,
    output logic [WDATA_W-1:0] o_mem_wr_data,
    output logic [ADDR_W-1:0]  o_mem_rd_addr,
    input  logic [RDATA_W-1:0] i_mem_rd_data,
    output logic               o_busy
);

    logic               last_gnt_q;
    logic               gnt0_q, gnt1_q;
    logic               gnt0_d, gnt1_d;
    logic               mem_wr_q, mem_rd_q;
    logic [ADDR_W-1:0]  wr_addr_q, rd_addr_q;
    logic [WDATA_W-1:0] wr_data_q;
    logic               rd_id_q;
    logic [RD_LAT-1:0]  tag_v_q, tag_v_d;
    logic [RD_LAT-1:0]  tag_id_q, tag_id_d;
    logic               rvalid0_q, rvalid1_q;
    logic [RDATA_W-1:0] rdata0_q, rdata1_q;
    logic               busy_q;

    logic               elig0, elig1;
    logic               any_gnt_d;
    logic               cmd_we;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [WDATA_W-1:0] cmd_wdata;
    logic               ret_v, ret_id;

    // Handshake: a requester holds req/we/addr/wdata until it sees its 1-cycle gnt
    // pulse; masking it during that pulse stops a held request being granted twice.
    always_comb begin
        elig0     = i_req0 & ~gnt0_q;
        elig1     = i_req1 & ~gnt1_q;
        gnt0_d    = elig0 & (~elig1 | last_gnt_q);
        gnt1_d    = elig1 & (~elig0 | ~last_gnt_q);
        any_gnt_d = gnt0_d | gnt1_d;
        cmd_we    = gnt1_d ? i_we1    : i_we0;
        cmd_addr  = gnt1_d ? i_addr1  : i_addr0;
        cmd_wdata = gnt1_d ? i_wdata1 : i_wdata0;
    end

    // Tag pipeline: stage RD_LAT-1 lines up with the cycle the memory presents data.
    always_comb begin
        tag_v_d  = '0;
        tag_id_d = '0;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
        tag_v_d[0]  = mem_rd_q;
        tag_id_d[0] = rd_id_q;
        ret_v       = tag_v_q[RD_LAT-1];
        ret_id      = tag_id_q[RD_LAT-1];
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            last_gnt_q <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_id_q    <= 1'b0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            mem_wr_q <= any_gnt_d & cmd_we;
            mem_rd_q <= any_gnt_d & ~cmd_we;
            if (any_gnt_d) begin
                last_gnt_q <= gnt1_d;
            end
            if (any_gnt_d && cmd_we) begin
                wr_addr_q <= cmd_addr;
                wr_data_q <= cmd_wdata;
            end
            if (any_gnt_d && !cmd_we) begin
                rd_addr_q <= cmd_addr;
                rd_id_q   <= gnt1_d;
            end
            tag_v_q   <= tag_v_d;
            tag_id_q  <= tag_id_d;
            busy_q    <= |tag_v_d;
            rvalid0_q <= ret_v & ~ret_id;
            rvalid1_q <= ret_v & ret_id;
            if (ret_v && !ret_id) begin
                rdata0_q <= i_mem_rd_data;
            end
            if (ret_v && ret_id) begin
                rdata1_q <= i_mem_rd_data;
            end
        end
    end

    assign o_gnt0        = gnt0_q;
    assign o_gnt1        = gnt1_q;
    assign o_mem_wr      = mem_wr_q;
    assign o_mem_rd      = mem_rd_q;
    assign o_mem_wr_addr = wr_addr_q;
    assign o_mem_wr_data = wr_data_q;
    assign o_mem_rd_addr = rd_addr_q;
    assign o_rvalid0     = rvalid0_q;
    assign o_rvalid1     = rvalid1_q;
    assign o_rdata0      = rdata0_q;
    assign o_rdata1      = rdata1_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// driven by the same requesters, each with its own behavioural memory.
module tb_mem_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, wdata0, addr1, wdata1;

    logic       d1_gnt0, d1_rv0, d1_gnt1, d1_rv1, d1_wr, d1_rd, d1_busy;
    logic [7:0] d1_rdata0, d1_rdata1, d1_mem_data;
    logic [3:0] d1_wr_addr, d1_wr_data, d1_rd_addr;
    logic       d3_gnt0, d3_rv0, d3_gnt1, d3_rv1, d3_wr, d3_rd, d3_busy;
    logic [7:0] d3_rdata0, d3_rdata1, d3_mem_data;
    logic [3:0] d3_wr_addr, d3_wr_data, d3_rd_addr;

    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] rp1;
    logic [7:0] rp3 [3];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.RD_LAT(1)) u_dut1 (
        .i_sys_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_gnt0(d1_gnt0), .o_rvalid0(d1_rv0), .o_rdata0(d1_rdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt1(d1_gnt1), .o_rvalid1(d1_rv1), .o_rdata1(d1_rdata1),
        .o_mem_wr(d1_wr), .o_mem_rd(d1_rd), .o_mem_wr_addr(d1_wr_addr),
        .o_mem_wr_data(d1_wr_data), .o_mem_rd_addr(d1_rd_addr),
        .i_mem_rd_data(d1_mem_data), .o_busy(d1_busy)
    );

    mem_rr_arbiter #(.RD_LAT(3)) u_dut3 (
        .i_sys_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_gnt0(d3_gnt0), .o_rvalid0(d3_rv0), .o_rdata0(d3_rdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt1(d3_gnt1), .o_rvalid1(d3_rv1), .o_rdata1(d3_rdata1),
        .o_mem_wr(d3_wr), .o_mem_rd(d3_rd), .o_mem_wr_addr(d3_wr_addr),
        .o_mem_wr_data(d3_wr_data), .o_mem_rd_addr(d3_rd_addr),
        .i_mem_rd_data(d3_mem_data), .o_busy(d3_busy)
    );

    // Behavioural memories: 4-bit writes stored zero-extended, reads returned RD_LAT cycles later.
    always @(posedge clk) begin
        if (d1_wr) mem1[d1_wr_addr] <= {4'h0, d1_wr_data};
        rp1 <= d1_rd ? mem1[d1_rd_addr] : 8'h00;
        if (d3_wr) mem3[d3_wr_addr] <= {4'h0, d3_wr_data};
        rp3[0] <= d3_rd ? mem3[d3_rd_addr] : 8'h00;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign d1_mem_data = rp1;
    assign d3_mem_data = rp3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".d1.gnt"},   {d1_gnt0, d1_gnt1}, 0);
        chk({tag, ".d1.rv"},    {d1_rv0, d1_rv1}, 0);
        chk({tag, ".d1.strb"},  {d1_wr, d1_rd}, 0);
        chk({tag, ".d1.busy"},  d1_busy, 0);
        chk({tag, ".d1.rdata"}, {d1_rdata0, d1_rdata1}, 0);
        chk({tag, ".d1.addr"},  {d1_wr_addr, d1_wr_data, d1_rd_addr}, 0);
        chk({tag, ".d3.gnt"},   {d3_gnt0, d3_gnt1}, 0);
        chk({tag, ".d3.rv"},    {d3_rv0, d3_rv1}, 0);
        chk({tag, ".d3.strb"},  {d3_wr, d3_rd}, 0);
        chk({tag, ".d3.busy"},  d3_busy, 0);
        chk({tag, ".d3.rdata"}, {d3_rdata0, d3_rdata1}, 0);
        chk({tag, ".d3.addr"},  {d3_wr_addr, d3_wr_data, d3_rd_addr}, 0);
    endtask

    // One read-phase cycle: grants, read strobe/address, and per-instance returns.
    task automatic cyc(input string tag, input logic g0, input logic g1, input logic [3:0] raddr,
                       input logic r0_1, input logic r1_1, input logic r0_3, input logic r1_3,
                       input logic [7:0] rd0, input logic [7:0] rd1);
        tick();
        chk({tag, ".d1.gnt0"}, d1_gnt0, g0);
        chk({tag, ".d1.gnt1"}, d1_gnt1, g1);
        chk({tag, ".d1.rd"},   d1_rd, g0 | g1);
        chk({tag, ".d1.wr"},   d1_wr, 0);
        chk({tag, ".d1.rv0"},  d1_rv0, r0_1);
        chk({tag, ".d1.rv1"},  d1_rv1, r1_1);
        chk({tag, ".d3.gnt0"}, d3_gnt0, g0);
        chk({tag, ".d3.gnt1"}, d3_gnt1, g1);
        chk({tag, ".d3.rd"},   d3_rd, g0 | g1);
        chk({tag, ".d3.wr"},   d3_wr, 0);
        chk({tag, ".d3.rv0"},  d3_rv0, r0_3);
        chk({tag, ".d3.rv1"},  d3_rv1, r1_3);
        if (g0 | g1) begin
            chk({tag, ".d1.raddr"}, d1_rd_addr, raddr);
            chk({tag, ".d3.raddr"}, d3_rd_addr, raddr);
        end
        if (r0_1) chk({tag, ".d1.rdata0"}, d1_rdata0, rd0);
        if (r1_1) chk({tag, ".d1.rdata1"}, d1_rdata1, rd1);
        if (r0_3) chk({tag, ".d3.rdata0"}, d3_rdata0, rd0);
        if (r1_3) chk({tag, ".d3.rdata1"}, d3_rdata1, rd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'h50 + 8'(i);
            mem3[i] = 8'h50 + 8'(i);
        end
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 4'h0; wdata0 = 4'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 4'h0; wdata1 = 4'h0;
        tick();
        tick();
        chk_idle("reset");

        // Requester 0 writes 0xA to address 3 in the first cycle out of reset.
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 4'hA;
        tick();
        chk("wr.d1.gnt", {d1_gnt0, d1_gnt1}, 2'b10);
        chk("wr.d1.strb", {d1_wr, d1_rd}, 2'b10);
        chk("wr.d1.cmd", {d1_wr_addr, d1_wr_data}, 8'h3A);
        chk("wr.d3.gnt", {d3_gnt0, d3_gnt1}, 2'b10);
        chk("wr.d3.strb", {d3_wr, d3_rd}, 2'b10);
        chk("wr.d3.cmd", {d3_wr_addr, d3_wr_data}, 8'h3A);
        req0 = 1'b0;
        tick();
        chk("wr_after.d1.gnt", {d1_gnt0, d1_gnt1, d1_wr, d1_rv0, d1_rv1, d1_busy}, 0);
        chk("wr_after.d1.hold", {d1_wr_addr, d1_wr_data}, 8'h3A);
        chk("wr_after.d3.gnt", {d3_gnt0, d3_gnt1, d3_wr, d3_rv0, d3_rv1, d3_busy}, 0);

        // Requester 1 reads back address 3.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
        cyc("rd1_c0", 0, 1, 4'h3, 0, 0, 0, 0, 8'h00, 8'h00);
        req1 = 1'b0;
        cyc("rd1_c1", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00);
        chk("rd1_c1.d1.busy", d1_busy, 1);
        chk("rd1_c1.d3.busy", d3_busy, 1);
        cyc("rd1_c2", 0, 0, 4'h0, 0, 1, 0, 0, 8'h00, 8'h0A);
        chk("rd1_c2.d1.busy", d1_busy, 0);
        chk("rd1_c2.d3.busy", d3_busy, 1);
        cyc("rd1_c3", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00);
        cyc("rd1_c4", 0, 0, 4'h0, 0, 0, 0, 1, 8'h00, 8'h0A);
        chk("rd1_c4.d3.busy", d3_busy, 0);

        // Both requesters hold reads: grants alternate starting with requester 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
        cyc("alt_1", 1, 0, 4'h1, 0, 0, 0, 0, 8'h51, 8'h52);
        cyc("alt_2", 0, 1, 4'h2, 0, 0, 0, 0, 8'h51, 8'h52);
        cyc("alt_3", 1, 0, 4'h1, 1, 0, 0, 0, 8'h51, 8'h52);
        cyc("alt_4", 0, 1, 4'h2, 0, 1, 0, 0, 8'h51, 8'h52);
        req0 = 1'b0; req1 = 1'b0;
        cyc("alt_5", 0, 0, 4'h0, 1, 0, 1, 0, 8'h51, 8'h52);
        cyc("alt_6", 0, 0, 4'h0, 0, 1, 0, 1, 8'h51, 8'h52);
        cyc("alt_7", 0, 0, 4'h0, 0, 0, 1, 0, 8'h51, 8'h52);
        cyc("alt_8", 0, 0, 4'h0, 0, 0, 0, 1, 8'h51, 8'h52);
        chk("alt_8.busy", {d1_busy, d3_busy}, 0);

        // Single requester holding its request: grants every other cycle.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
        cyc("one_1", 0, 1, 4'h2, 0, 0, 0, 0, 8'h00, 8'h52);
        cyc("one_2", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h52);
        cyc("one_3", 0, 1, 4'h2, 0, 1, 0, 0, 8'h00, 8'h52);
        cyc("one_4", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h52);
        cyc("one_5", 0, 1, 4'h2, 0, 1, 0, 1, 8'h00, 8'h52);
        req1 = 1'b0;
        cyc("one_6", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h52);
        cyc("one_7", 0, 0, 4'h0, 0, 1, 0, 1, 8'h00, 8'h52);
        cyc("one_8", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h52);
        cyc("one_9", 0, 0, 4'h0, 0, 0, 0, 1, 8'h00, 8'h52);

        // Three back-to-back reads, then a one-cycle reset with tags in flight.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
        cyc("rst_1", 1, 0, 4'h1, 0, 0, 0, 0, 8'h51, 8'h52);
        cyc("rst_2", 0, 1, 4'h2, 0, 0, 0, 0, 8'h51, 8'h52);
        cyc("rst_3", 1, 0, 4'h1, 1, 0, 0, 0, 8'h51, 8'h52);
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1;
        tick();
        chk_idle("rst_4");
        rst = 1'b0;
        cyc("rst_5", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00);
        cyc("rst_6", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00);
        cyc("rst_7", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00);
        cyc("rst_8", 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h00);
        chk("rst_8.busy", {d1_busy, d3_busy}, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester, round-robin arbiter sequencing access to the single-port `memory` block.
  - `memory` has 4-bit write/read addresses, 4-bit write data and 8-bit read data.
- Each requester issues single-beat read or write commands with a req/gnt handshake.
- The arbiter serialises the granted commands onto the memory strobes and routes the read data back to the issuing requester with a valid pulse.
- It sits directly in front of `memory`, replacing the free-running stimulus that drives that block today.

Parameters:
- ADDR_W, 4, memory address width
- WDATA_W, 4, write data width
- RDATA_W, 8, read data width
- RD_LAT, 1, memory read latency in cycles, legal range 1..4

Ports:
- i_sys_clk  in  1  system clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req0  in  1  requester 0 command request
- i_we0  in  1  requester 0 command type: 1 = write, 0 = read
- i_addr0  in  ADDR_W  requester 0 address
- i_wdata0  in  WDATA_W  requester 0 write data
- o_gnt0  out  1  requester 0 command accepted (1-cycle pulse)
- o_rvalid0  out  1  requester 0 read data valid (1-cycle pulse)
- o_rdata0  out  RDATA_W  requester 0 read data
- i_req1, i_we1, i_addr1, i_wdata1, o_gnt1, o_rvalid1, o_rdata1: same as requester 0, for requester 1
- o_mem_wr  out  1  to memory i_wr
- o_mem_rd  out  1  to memory i_rd
- o_mem_wr_addr  out  ADDR_W  to memory i_wr_addr
- o_mem_wr_data  out  WDATA_W  to memory i_wr_data
- o_mem_rd_addr  out  ADDR_W  to memory i_rd_addr
- i_mem_rd_data  in  RDATA_W  from memory o_rd_data
- o_busy  out  1  read return pipeline non-empty

Behaviour:
- Clocking and reset:
  - All state advances on the rising edge of i_sys_clk. All outputs are registered.
  - While i_rst=1, every output is 0 and the read tag pipeline is cleared.
  - The round-robin pointer last_gnt is set to 1, so requester 0 wins the first tie.
- Reset mid-operation:
  - In-flight reads are discarded; no o_rvalid is produced for them.
  - The first grant after reset release can occur on the edge following the first cycle with i_rst=0.
- Eligibility:
  - Requester n is eligible in cycle C if i_reqn=1 and o_gntn=0 in cycle C.
  - This masks a requester in its own grant cycle and prevents double-granting a held request.
- Arbitration, evaluated every cycle:
  - No eligible requester: no grant.
  - One eligible requester: grant it.
  - Both eligible: grant the requester that is not last_gnt.
  - On every grant, last_gnt is updated to the granted requester.
- Grant timing:
  - If requester n is selected in cycle C, o_gntn=1 in cycle C+1 only.
  - In that same cycle C+1, the memory command is driven from the command values sampled in cycle C.
- Requester rule:
  - req, we, addr and wdata are held stable from assertion until o_gnt is seen.
  - In the o_gnt cycle the requester drops req or presents its next command.
  - A requester can therefore issue at most one command per 2 cycles. Two alternating requesters give one command per cycle.
- Memory command:
  - Write: o_mem_wr=1, o_mem_wr_addr=addr, o_mem_wr_data=wdata.
  - Read: o_mem_rd=1, o_mem_rd_addr=addr.
  - o_mem_wr and o_mem_rd are never both 1. Both are 0 in non-grant cycles.
  - Address and data outputs that are not used by the current command hold their previous values.
- Read return:
  - A read command issued in cycle C pushes tag {valid=1, id=n} into an RD_LAT-deep shift register.
  - i_mem_rd_data is valid in cycle C+RD_LAT. It is registered into o_rdatan, with o_rvalidn=1 in cycle C+RD_LAT+1, a 1-cycle pulse.
  - o_rdatan holds its last value when o_rvalidn=0.
  - The other requester's rdata/rvalid are unaffected.
  - Writes generate no return.
- Throughput and busy:
  - Back-to-back reads are fully pipelined; no stall is ever generated.
  - o_busy=1 whenever any tag in the pipeline is valid.
- Read-after-write ordering: a read granted the cycle after a write to the same address returns whatever `memory` produces. The arbiter does no forwarding.

Test Plan:
- Reset release, then req0 write addr=3 data=0xA held: o_gnt0 and o_mem_wr=1, wr_addr=3, wr_data=0xA exactly 1 cycle after first sampled req; single pulse; no o_rvalid.
- Requester 0 writes addr 3 = 0xA, then req1 reads addr 3: o_mem_rd=1, rd_addr=3 in the grant cycle; o_rvalid1=1 RD_LAT+1 cycles later with o_rdata1=0x0A; o_rvalid0 stays 0.
- Both requesters hold reads continuously (addrs 1 and 2): grants alternate 0,1,0,1 every cycle; never two grants in one cycle; each rvalid is routed to the correct id.
- Single requester holds req through gnt: grants spaced exactly 2 cycles apart, never consecutive.
- Issue 3 back-to-back reads, then assert i_rst for 1 cycle while tags are in flight: no o_rvalid after reset; all outputs 0; o_busy=0.
- Repeat the scenario 2 read and scenario 3 with RD_LAT=3: rvalid appears 4 cycles after the o_mem_rd cycle; order is preserved.
